// File: rtl/commit_pkg.sv
// commit_pkg: shared constants and types for the commit arbiter slice.
//   N_INSTR_BRANCHES - default number of execute branches presenting results
//   CID_W            - commit_id width (ids wrap modulo 2**CID_W)
//   STALL_LIMIT_DEF  - default wait-counter limit before stall_error
package commit_pkg;
  localparam int N_INSTR_BRANCHES = 4;
  localparam int CID_W            = 9;
  localparam int STALL_LIMIT_DEF  = 255;

  typedef logic [CID_W-1:0] cid_t;
endpackage

// File: rtl/commit_match.sv
// commit_match: combinational in-order match and priority encoder.
//   valid/id    - per-branch result valid and commit_id
//   expected_id - next commit_id allowed to retire
//   grant_idx   - lowest-index matching branch (meaningful when grant_vld)
//   grant_vld   - at least one branch matches
//   multi       - more than one branch matches (duplicate commit_id)
module commit_match
  import commit_pkg::*;
#(
  parameter int NB    = N_INSTR_BRANCHES,
  parameter int IDX_W = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic [NB-1:0]      valid,
  input  cid_t [NB-1:0]      id,
  input  cid_t               expected_id,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld,
  output logic               multi
);
  logic [NB-1:0] match;

  always_comb begin
    match     = '0;
    grant_idx = '0;
    for (int i = 0; i < NB; i++)
      match[i] = valid[i] && (id[i] == expected_id);
    // Scan high to low so the lowest matching index is the last assignment.
    for (int i = NB-1; i >= 0; i--)
      if (match[i]) grant_idx = IDX_W'(i);
    grant_vld = |match;
    // Clearing the lowest set bit leaves something only if two or more match.
    multi     = |(match & (match - NB'(1)));
  end
endmodule

// File: rtl/commit_arbiter.sv
// commit_arbiter: retires execute results strictly in commit_id order.
//   clk/reset          - clock, async active-low reset
//   enable             - global enable; low freezes state and masks outputs
//   clear              - synchronous restart of the commit sequence
//   res_*              - per-branch result bus; res_ready is the combinational accept
//   channel_write_*    - channel file write port (registered)
//   acc_write_*        - accumulator write port (registered)
//   ext_write_*        - external write port (registered)
//   expected_id        - next commit_id to retire
//   stall_error        - sticky, a pending result waited stall_limit cycles
//   order_error        - sticky, two branches presented the expected id together
module commit_arbiter
  import commit_pkg::*;
#(
  parameter int data_width  = 16,
  parameter int n_branches  = N_INSTR_BRANCHES,
  parameter int stall_limit = STALL_LIMIT_DEF
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic [n_branches-1:0]                 res_valid,
  output logic [n_branches-1:0]                 res_ready,
  input  logic [n_branches-1:0][CID_W-1:0]      res_commit_id,
  input  logic [n_branches-1:0][3:0]            res_dest,
  input  logic [n_branches-1:0]                 res_dest_acc,
  input  logic [n_branches-1:0]                 res_ext_write,
  input  logic [n_branches-1:0][data_width-1:0] res_val,
  input  logic [n_branches-1:0][2*data_width-1:0] res_acc,
  input  logic                                  clear,
  output logic [3:0]                            channel_write_addr,
  output logic [data_width-1:0]                 channel_write_val,
  output logic                                  channel_write_enable,
  output logic [2*data_width-1:0]               acc_write_val,
  output logic                                  acc_write_enable,
  output logic [data_width-1:0]                 ext_write_val,
  output logic                                  ext_write_enable,
  output logic [CID_W-1:0]                      expected_id,
  output logic                                  stall_error,
  output logic                                  order_error
);
  localparam int IDX_W = (n_branches > 1) ? $clog2(n_branches) : 1;
  localparam int CNT_W = $clog2(stall_limit + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(stall_limit);

  logic [IDX_W-1:0] grant_idx;
  logic             grant_vld, multi, grant;
  logic [CNT_W-1:0] wait_cnt;
  logic             wr_ch, wr_acc, wr_ext;

  commit_match #(.NB(n_branches), .IDX_W(IDX_W)) u_match (
    .valid       (res_valid),
    .id          (res_commit_id),
    .expected_id (expected_id),
    .grant_idx   (grant_idx),
    .grant_vld   (grant_vld),
    .multi       (multi)
  );

  // reset is folded in so ready drops the instant reset asserts.
  assign grant = grant_vld && enable && !clear && reset;

  always_comb begin
    res_ready = '0;
    for (int i = 0; i < n_branches; i++)
      res_ready[i] = grant && (grant_idx == IDX_W'(i));
  end

  // Pending strobes are held while disabled, so they are masked here.
  assign channel_write_enable = wr_ch  && enable;
  assign acc_write_enable     = wr_acc && enable;
  assign ext_write_enable     = wr_ext && enable;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expected_id        <= '0;
      wait_cnt           <= '0;
      stall_error        <= 1'b0;
      order_error        <= 1'b0;
      wr_ch              <= 1'b0;
      wr_acc             <= 1'b0;
      wr_ext             <= 1'b0;
      channel_write_addr <= '0;
      channel_write_val  <= '0;
      acc_write_val      <= '0;
      ext_write_val      <= '0;
    end else if (enable) begin
      wr_ch  <= 1'b0;
      wr_acc <= 1'b0;
      wr_ext <= 1'b0;
      if (grant) begin
        // Destination priority: accumulator, then external, then channel.
        if (res_dest_acc[grant_idx]) begin
          wr_acc        <= 1'b1;
          acc_write_val <= res_acc[grant_idx];
        end else if (res_ext_write[grant_idx]) begin
          wr_ext        <= 1'b1;
          ext_write_val <= res_val[grant_idx];
        end else begin
          wr_ch              <= 1'b1;
          channel_write_addr <= res_dest[grant_idx];
          channel_write_val  <= res_val[grant_idx];
        end
        if (multi) order_error <= 1'b1;
      end

      if (clear)      expected_id <= '0;
      else if (grant) expected_id <= expected_id + CID_W'(1);

      if (clear || grant || !(|res_valid)) begin
        wait_cnt <= '0;
      end else if (wait_cnt != LIM) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
        if (wait_cnt + CNT_W'(1) == LIM) stall_error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_commit_arbiter.sv
module tb_commit_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;

  logic clk = 1'b0, reset = 1'b0, enable = 1'b1, clear = 1'b0;
  logic [N-1:0]           res_valid = '0, res_ready;
  logic [N-1:0][8:0]      cid = '0;
  logic [N-1:0][3:0]      dest = '0;
  logic [N-1:0]           dacc = '0, ext = '0;
  logic [N-1:0][DW-1:0]   val = '0;
  logic [N-1:0][2*DW-1:0] acc = '0;
  logic [3:0]             ch_addr;
  logic [DW-1:0]          ch_val, ext_val;
  logic [2*DW-1:0]        acc_val;
  logic                   ch_en, acc_en, ext_en, stall_error, order_error;
  logic [8:0]             expected_id;

  int total = 0, fails = 0;

  commit_arbiter #(.data_width(DW), .n_branches(N), .stall_limit(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .res_valid(res_valid), .res_ready(res_ready), .res_commit_id(cid),
    .res_dest(dest), .res_dest_acc(dacc), .res_ext_write(ext),
    .res_val(val), .res_acc(acc), .clear(clear),
    .channel_write_addr(ch_addr), .channel_write_val(ch_val),
    .channel_write_enable(ch_en), .acc_write_val(acc_val),
    .acc_write_enable(acc_en), .ext_write_val(ext_val),
    .ext_write_enable(ext_en), .expected_id(expected_id),
    .stall_error(stall_error), .order_error(order_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state, with a matching result already presented.
    res_valid = 4'b0001; cid[0] = 9'd0; dest[0] = 4'd3; val[0] = 16'h1234;
    cid[1] = 9'd1; dest[1] = 4'd5; val[1] = 16'hBEEF;
    #12;
    chk("rst_ready", 64'(res_ready), 64'h0);
    chk("rst_exp", 64'(expected_id), 64'h0);
    chk("rst_en", 64'({ch_en, acc_en, ext_en}), 64'h0);
    chk("rst_err", 64'({stall_error, order_error}), 64'h0);
    chk("rst_data", 64'({ch_addr, ch_val, ext_val, acc_val}), 64'h0);
    reset = 1'b1;

    // Ordered retire: id 0 then id 1.
    res_valid = 4'b0011; #1;
    chk("ord_ready0", 64'(res_ready), 64'h1);
    step();
    chk("ord_wr0", 64'({ch_en, ch_addr, ch_val}), {44'h0, 1'b1, 4'd3, 16'h1234});
    chk("ord_exp1", 64'(expected_id), 64'd1);
    res_valid = 4'b0010; #1;
    chk("ord_ready1", 64'(res_ready), 64'h2);
    step();
    chk("ord_wr1", 64'({ch_en, ch_addr, ch_val}), {44'h0, 1'b1, 4'd5, 16'hBEEF});
    chk("ord_exp2", 64'(expected_id), 64'd2);
    res_valid = '0;
    step();
    chk("ord_idle", 64'({ch_en, acc_en, ext_en}), 64'h0);

    // Out-of-order: id 3 arrives three cycles before id 2.
    res_valid = 4'b0010; cid[1] = 9'd3; dacc[1] = 1'b1; acc[1] = 32'h12345678;
    for (int c = 0; c < 3; c++) begin
      #1; chk("ooo_bp", 64'(res_ready), 64'h0);
      step();
    end
    chk("ooo_nostall", 64'(stall_error), 64'h0);
    res_valid = 4'b0011; cid[0] = 9'd2; ext[0] = 1'b1; val[0] = 16'h00AA; #1;
    chk("ooo_ready0", 64'(res_ready), 64'h1);
    step();
    chk("ooo_ext", 64'({ext_en, ch_en, acc_en, ext_val}), {45'h0, 3'b100, 16'h00AA});
    chk("ooo_exp3", 64'(expected_id), 64'd3);
    res_valid = 4'b0010; #1;
    chk("ooo_ready1", 64'(res_ready), 64'h2);
    step();
    chk("ooo_acc", 64'({acc_en, ch_en, ext_en, acc_val}), {29'h0, 3'b100, 32'h12345678});
    chk("ooo_exp4", 64'(expected_id), 64'd4);
    chk("ooo_nostall2", 64'(stall_error), 64'h0);
    res_valid = '0; ext[0] = 1'b0; dacc[1] = 1'b0;

    // Duplicate id on branches 0 and 3.
    res_valid = 4'b1001; cid[0] = 9'd4; cid[3] = 9'd4; dest[0] = 4'd1; val[0] = 16'h1111;
    #1; chk("dup_ready", 64'(res_ready), 64'h1);
    chk("dup_noerr", 64'(order_error), 64'h0);
    step();
    chk("dup_err", 64'(order_error), 64'h1);
    chk("dup_wr", 64'({ch_en, ch_addr, ch_val}), {44'h0, 1'b1, 4'd1, 16'h1111});
    chk("dup_exp5", 64'(expected_id), 64'd5);

    // Enable low: match present, but nothing moves and strobes read 0.
    res_valid = 4'b0001; cid[0] = 9'd5; enable = 1'b0; #1;
    chk("en_ready", 64'(res_ready), 64'h0);
    chk("en_mask", 64'(ch_en), 64'h0);
    step();
    chk("en_exp", 64'(expected_id), 64'd5);
    chk("en_mask2", 64'(ch_en), 64'h0);

    // Clear beats a same-cycle match.
    enable = 1'b1; clear = 1'b1; #1;
    chk("clr_ready", 64'(res_ready), 64'h0);
    step();
    chk("clr_exp", 64'(expected_id), 64'd0);
    chk("clr_nowr", 64'({ch_en, acc_en, ext_en}), 64'h0);
    clear = 1'b0;

    // Timeout: id 7 waits against expected 0, limit 4.
    cid[0] = 9'd7; #1;
    chk("to_ready", 64'(res_ready), 64'h0);
    step(); step(); step();
    chk("to_3cyc", 64'(stall_error), 64'h0);
    step();
    chk("to_4cyc", 64'(stall_error), 64'h1);
    chk("to_ready2", 64'(res_ready), 64'h0);
    chk("to_exp", 64'(expected_id), 64'd0);
    res_valid = '0;

    // Wrap: retire ids 0..510 via branch 2, then 511.
    for (int i = 0; i < 511; i++) begin
      res_valid = 4'b0100; cid[2] = 9'(i);
      step();
    end
    chk("wrap_511", 64'(expected_id), 64'd511);
    cid[2] = 9'd511; dest[2] = 4'd9; val[2] = 16'h5A5A; #1;
    chk("wrap_ready", 64'(res_ready), 64'h4);
    step();
    chk("wrap_wr", 64'({ch_en, ch_addr, ch_val}), {44'h0, 1'b1, 4'd9, 16'h5A5A});
    chk("wrap_exp0", 64'(expected_id), 64'd0);
    res_valid = '0;

    // Async reset between edges while a write is on the port.
    res_valid = 4'b0001; cid[0] = 9'd0; dest[0] = 4'd2; val[0] = 16'h7777;
    step();
    chk("ar_pend", 64'(ch_en), 64'h1);
    #3 reset = 1'b0; #1;
    chk("ar_en", 64'({ch_en, acc_en, ext_en}), 64'h0);
    chk("ar_data", 64'({ch_addr, ch_val}), 64'h0);
    chk("ar_exp", 64'(expected_id), 64'd0);
    chk("ar_err", 64'({stall_error, order_error}), 64'h0);
    chk("ar_ready", 64'(res_ready), 64'h0);
    res_valid = '0; #2 reset = 1'b1;
    step();
    chk("ar_post_exp", 64'(expected_id), 64'd0);
    chk("ar_post_en", 64'(ch_en), 64'h0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
